// File: rtl/hamming_encode_arbiter.sv
// Round-robin arbiter sharing one extended-Hamming (SECDED) encoder among N_REQ
// requesters; the codeword sits in a one-entry valid/ready output register.
module hamming_encode_arbiter #(
  parameter  int P_BITS   = 3,
  parameter  int N_REQ    = 4,
  localparam int IP_WIDTH = (1 << P_BITS) - P_BITS - 1,
  localparam int CW_WIDTH = (1 << P_BITS),
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*IP_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cw_valid,
  output logic [CW_WIDTH-1:0]       cw_data,
  output logic [SRC_W-1:0]          cw_src,
  input  logic                      cw_ready,
  output logic [15:0]               cw_count
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_r;
  logic [SRC_W-1:0]     rr_ptr_r;
  logic [SRC_W-1:0]     winner_s;
  logic                 found_s;
  logic                 hit_s;
  int                   idx_s;
  logic                 take_s;
  logic                 grant_s;
  logic [IP_WIDTH-1:0]  word_s;

  // Data bits fill non-power-of-two positions from 3 upward; parity 2^k covers
  // every position with bit k set; bit 0 makes overall parity even.
  function automatic logic [CW_WIDTH-1:0] encode(input logic [IP_WIDTH-1:0] d);
    logic [CW_WIDTH-1:0] c;
    logic                par;
    int                  di;
    c  = '0;
    di = 0;
    for (int p = 1; p < CW_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[di];
        di   = di + 1;
      end
    end
    for (int k = 0; k < P_BITS; k++) begin
      par = 1'b0;
      for (int p = 1; p < CW_WIDTH; p++) begin
        if (((p >> k) & 1) == 1) begin
          par = par ^ c[p];
        end
      end
      c[1 << k] = par;
    end
    c[0] = ^c[CW_WIDTH-1:1];
    return c;
  endfunction

  // Round-robin winner search starting at rr_ptr_r, plus grant/ready generation.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    idx_s    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s    = (int'(rr_ptr_r) + i) % N_REQ;
      hit_s    = req_valid[idx_s] & ~found_s;
      winner_s = hit_s ? SRC_W'(idx_s) : winner_s;
      found_s  = found_s | hit_s;
    end
    word_s    = req_data[winner_s*IP_WIDTH +: IP_WIDTH];
    take_s    = (state_r == EMPTY) | (cw_ready & cw_valid);
    grant_s   = take_s & found_s;
    req_ready = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner_s) : {N_REQ{1'b0}};
  end

  // Output-register FSM, round-robin pointer and delivered-codeword counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= EMPTY;
      cw_valid <= 1'b0;
      cw_data  <= '0;
      cw_src   <= '0;
      cw_count <= 16'h0000;
      rr_ptr_r <= '0;
    end else begin
      if (cw_valid & cw_ready) begin
        cw_count <= cw_count + 16'h0001;
      end
      if (grant_s) begin
        cw_data  <= encode(word_s);
        cw_src   <= winner_s;
        rr_ptr_r <= (winner_s == SRC_W'(N_REQ - 1)) ? '0 : winner_s + SRC_W'(1);
      end
      case (state_r)
        EMPTY: begin
          if (grant_s) begin
            state_r  <= FULL;
            cw_valid <= 1'b1;
          end
        end
        FULL: begin
          // A drain with no refill empties the register; a stall holds it.
          if (cw_ready & ~found_s) begin
            state_r  <= EMPTY;
            cw_valid <= 1'b0;
          end
        end
        default: begin
          state_r  <= EMPTY;
          cw_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
